// File: rtl/logic_pkg.sv
// Shared opcode definitions for the bitwise logic unit.
package logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_XNOR = 3'b011,
    OP_NOTA = 3'b100,
    OP_XACC = 3'b101,
    OP_ACLR = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

endpackage

// File: rtl/logic_unit_n_if.sv
// Operand/result handshake bundle for logic_unit_n.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// source holds its payload stable while valid && !ready, and ready may depend
// combinationally on the downstream ready.
interface logic_unit_n_if
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_zero;
  logic             out_parity;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_s, out_zero, out_parity, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_s, out_zero, out_parity, out_err
  );
endinterface

// File: rtl/logic_core.sv
// Combinational operation decoder: computes the result and the accumulator
// update for one operand pair.
module logic_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_next,
  output logic             acc_we,
  output logic             err
);

  always_comb begin
    result   = '0;
    acc_next = acc;
    acc_we   = 1'b0;
    err      = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOTA: result = ~a;
      OP_XACC: begin
        acc_next = acc ^ a ^ b;
        acc_we   = 1'b1;
        result   = acc ^ a ^ b;
      end
      // Read-and-clear: report the old value, leave zero behind.
      OP_ACLR: begin
        result   = acc;
        acc_next = '0;
        acc_we   = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_n.sv
// Registered WIDTH-bit logic unit with XOR-checksum accumulator, result flags
// and valid/ready on both sides; one cycle from acceptance to result.
module logic_unit_n
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  logic_unit_n_if.slave  bus
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] core_acc_next;
  logic             core_acc_we;
  logic             core_err;
  logic             accept;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .op       (op_e'(bus.in_op)),
    .a        (bus.in_a),
    .b        (bus.in_b),
    .acc      (acc_q),
    .result   (core_result),
    .acc_next (core_acc_next),
    .acc_we   (core_acc_we),
    .err      (core_err)
  );

  // Ready follows out_ready combinationally so a pop and a push share an edge.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    acc_d    = acc_q;
    s_d      = s_q;
    valid_d  = valid_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    err_d    = err_q;
    if (accept) begin
      s_d      = core_result;
      zero_d   = (core_result == '0);
      parity_d = ^core_result;
      err_d    = core_err;
      valid_d  = 1'b1;
      if (core_acc_we) acc_d = core_acc_next;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      s_q      <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_s      = s_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_parity = parity_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_logic_unit_n.sv
// Self-checking bench for logic_unit_n: directed scenarios, a random stream
// and a scoreboard of {err, parity, zero, s} results.
module tb_logic_unit_n;
  import logic_pkg::*;

  localparam int W  = 16;
  localparam int EW = W + 3;

  logic clk;
  logic rst_n;

  logic_unit_n_if #(.WIDTH(W)) bus ();

  logic_unit_n #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  m_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour from the operation table; updates the bench accumulator.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic e;
    e = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a ^ b);
      3'd4: r = ~a;
      3'd5: begin m_acc = m_acc ^ a ^ b; r = m_acc; end
      3'd6: begin r = m_acc; m_acc = '0; end
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, ^r, (r == '0), r};
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic drive_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(model(op, a, b));
        done = 1'b1;
      end else begin
        waits++;
      end
      @(negedge clk);
      if (!done) bus.out_ready = 1'b1;
    end
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Results are compared at the moment they are popped.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_s", 32'(bus.out_s), 32'(e[W-1:0]));
        check_eq("out_flags", {29'd0, bus.out_err, bus.out_parity, bus.out_zero},
                 {29'd0, e[EW-1:W]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [2:0] r_op;
    n_vec = 0;
    n_err = 0;
    m_acc = '0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_XOR;
    bus.in_a      = 16'h0475;
    bus.in_b      = 16'h5976;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid",  32'(bus.out_valid), 32'd0);
    check_eq("rst_s",      32'(bus.out_s), 32'd0);
    check_eq("rst_flags",  {29'd0, bus.out_err, bus.out_parity, bus.out_zero}, 32'd1);
    rst_n = 1'b1;

    // First transfer must be taken on the first edge after release.
    drive_op(OP_XOR, 16'h0475, 16'h5976, w);
    check_eq("first_accept_waits", 32'(w), 32'd0);

    drive_op(OP_XACC, 16'h0475, 16'h5976, w);
    drive_op(OP_XACC, 16'h7475, 16'h5996, w);
    drive_op(OP_ACLR, 16'h1111, 16'h2222, w);
    drive_op(OP_XACC, 16'h0000, 16'h0000, w);
    idle(2);

    // Backpressure: hold an AND result while the source keeps changing.
    bus.out_ready = 1'b0;
    drive_op(OP_AND, 16'hFF00, 16'h0FF0, w);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_XACC;
      bus.in_a     = 16'($urandom_range(1, 16'hFFFF));
      bus.in_b     = 16'h0;
      #1;
      check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_s", 32'(bus.out_s), 32'h0F00);
      check_eq("stall_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    drive_op(OP_ACLR, 16'h0, 16'h0, w);
    check_eq("release_accept_waits", 32'(w), 32'd0);
    idle(2);

    // All eight opcodes streamed back to back.
    for (int op = 0; op < 8; op++) drive_op(3'(op), 16'hA5A5, 16'h0FF0, w);
    idle(2);

    // Random stream with random downstream stalls.
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      r_op = 3'($urandom_range(0, 7));
      drive_op(r_op, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), w);
    end
    bus.out_ready = 1'b1;
    idle(3);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a held result and a nonzero accumulator.
    bus.out_ready = 1'b0;
    drive_op(OP_XACC, 16'h1234, 16'h0000, w);
    bus.in_valid = 1'b0;
    #2;
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("async_rst_zero", 32'(bus.out_zero), 32'd1);
    exp_q.delete();
    m_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive_op(OP_XACC, 16'h0001, 16'h0000, w);
    idle(3);
    check_eq("final_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
